// File: rtl/dma_wch_sched_pkg.sv
// Shared definitions for the DMA write-channel scheduler.
// State encoding, descriptor layout and default length limit.
package dma_sch_pkg;

  localparam int DAW  = 32;
  localparam int LENW = 16;

  localparam logic [LENW-1:0] MAX_XSIZE_DEF = 16'hFFF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_REJ  = 3'd5;

  typedef struct packed {
    logic [DAW-1:0]  dar;
    logic [LENW-1:0] xsize;
    logic [LENW-1:0] ysize;
    logic [LENW-1:0] ystep;
  } desc_t;

endpackage

// File: rtl/dma_wch_sched_rr_arb.sv
// Combinational round-robin search: first set req bit after ptr,
// wrapping; returns one-hot grant and its index.
module rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk from the farthest slot back so the nearest one lands last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dma_wch_sched.sv
// Round-robin owner of the 2D DMA write command generator.
// Optional watchdog enabled by defining DMA_WCH_WDOG_EN.
module dma_wch_sched
  import dma_sch_pkg::*;
#(
  parameter int              NCH       = 4,
  parameter int              CHW       = 2,
  parameter logic [LENW-1:0] MAX_XSIZE = MAX_XSIZE_DEF,
  parameter int unsigned     WDOG_CYC  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*32-1:0] ch_dar,
  input  logic [NCH*16-1:0] ch_xsize,
  input  logic [NCH*16-1:0] ch_ysize,
  input  logic [NCH*16-1:0] ch_ystep,
  output logic [NCH-1:0]    ch_gnt,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_rej,
  output logic [CHW-1:0]    cur_ch,
  output logic              dma_cmd_sof,
  input  logic              dma_cmd_end,
  output logic              dma_busy,
  output logic [31:0]       cfg_dar,
  output logic [15:0]       cfg_trans_xsize,
  output logic [15:0]       cfg_trans_ysize,
  output logic [15:0]       cfg_da_ystep,
  input  logic              buf_err,
  output logic              clr_buf_err,
  output logic [NCH-1:0]    wdog_err
);

  logic [2:0]     state;
  logic [2:0]     nxt;
  desc_t          desc;
  desc_t          win_d;
  logic [CHW-1:0] cur_q;
  logic [CHW-1:0] ptr_q;
  logic           busy_q;
  logic [NCH-1:0] arb_gnt;
  logic [CHW-1:0] arb_idx;
  logic           arb_any;
  logic [NCH-1:0] cur_oh;

  rr_arb #(.N(NCH), .W(CHW)) u_arb (
    .req (ch_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    win_d.dar   = ch_dar[int'(arb_idx)*DAW +: DAW];
    win_d.xsize = ch_xsize[int'(arb_idx)*LENW +: LENW];
    win_d.ysize = ch_ysize[int'(arb_idx)*LENW +: LENW];
    win_d.ystep = ch_ystep[int'(arb_idx)*LENW +: LENW];
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (|ch_req) nxt = S_ARB;
      S_ARB: begin
        if (!arb_any)                    nxt = S_IDLE;
        else if (win_d.xsize > MAX_XSIZE) nxt = S_REJ;
        else                              nxt = S_LOAD;
      end
      S_LOAD: nxt = S_RUN;
      S_RUN:  if (dma_cmd_end) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      S_REJ:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      desc   <= '0;
      cur_q  <= '0;
      ptr_q  <= CHW'(NCH - 1);
      busy_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_ARB && arb_any) begin
        desc  <= win_d;
        cur_q <= arb_idx;
        ptr_q <= arb_idx;
      end
      if (state == S_LOAD)      busy_q <= 1'b1;
      else if (state == S_DONE) busy_q <= 1'b0;
    end
  end

  assign cur_oh = NCH'(1) << cur_q;

  assign ch_gnt      = (state == S_ARB)  ? arb_gnt : '0;
  assign ch_done     = (state == S_DONE) ? cur_oh  : '0;
  assign ch_rej      = (state == S_REJ)  ? cur_oh  : '0;
  assign dma_cmd_sof = (state == S_LOAD);
  assign clr_buf_err = (state == S_DONE) && buf_err;
  assign dma_busy    = busy_q;
  assign cur_ch      = cur_q;

  assign cfg_dar         = desc.dar;
  assign cfg_trans_xsize = desc.xsize;
  assign cfg_trans_ysize = desc.ysize;
  assign cfg_da_ystep    = desc.ystep;

`ifdef DMA_WCH_WDOG_EN
  logic [31:0]    wd_cnt;
  logic [NCH-1:0] wd_err;

  // Saturates at the limit; the flag only reports, it never aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_err <= '0;
    end else if (state == S_LOAD) begin
      wd_cnt <= '0;
    end else if (state == S_RUN && wd_cnt != 32'(WDOG_CYC)) begin
      wd_cnt <= wd_cnt + 32'd1;
      if (wd_cnt + 32'd1 == 32'(WDOG_CYC)) wd_err[cur_q] <= 1'b1;
    end
  end

  assign wdog_err = wd_err;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
  assign wdog_err    = '0;
`endif

endmodule

// File: tb/tb_dma_wch_sched.sv
// Bench for dma_wch_sched: vector table, reset/order sequences and
// randomized traffic against a transaction-level round-robin model.
module tb_dma_wch_sched;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     ch_req;
  logic [127:0]   ch_dar;
  logic [63:0]    ch_xsize;
  logic [63:0]    ch_ysize;
  logic [63:0]    ch_ystep;
  logic [3:0]     ch_gnt;
  logic [3:0]     ch_done;
  logic [3:0]     ch_rej;
  logic [1:0]     cur_ch;
  logic           dma_cmd_sof;
  logic           dma_cmd_end;
  logic           dma_busy;
  logic [31:0]    cfg_dar;
  logic [15:0]    cfg_trans_xsize;
  logic [15:0]    cfg_trans_ysize;
  logic [15:0]    cfg_da_ystep;
  logic           buf_err;
  logic           clr_buf_err;
  logic [3:0]     wdog_err;

  dma_wch_sched #(.NCH(4), .CHW(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_req          (ch_req),
    .ch_dar          (ch_dar),
    .ch_xsize        (ch_xsize),
    .ch_ysize        (ch_ysize),
    .ch_ystep        (ch_ystep),
    .ch_gnt          (ch_gnt),
    .ch_done         (ch_done),
    .ch_rej          (ch_rej),
    .cur_ch          (cur_ch),
    .dma_cmd_sof     (dma_cmd_sof),
    .dma_cmd_end     (dma_cmd_end),
    .dma_busy        (dma_busy),
    .cfg_dar         (cfg_dar),
    .cfg_trans_xsize (cfg_trans_xsize),
    .cfg_trans_ysize (cfg_trans_ysize),
    .cfg_da_ystep    (cfg_da_ystep),
    .buf_err         (buf_err),
    .clr_buf_err     (clr_buf_err),
    .wdog_err        (wdog_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  logic [31:0] m_dar[4];
  logic [15:0] m_xs[4];
  logic [15:0] m_ys[4];
  logic [15:0] m_yst[4];

  task automatic put_desc();
    for (int i = 0; i < NCH; i++) begin
      ch_dar[i*32 +: 32]   = m_dar[i];
      ch_xsize[i*16 +: 16] = m_xs[i];
      ch_ysize[i*16 +: 16] = m_ys[i];
      ch_ystep[i*16 +: 16] = m_yst[i];
    end
  endtask

  function automatic logic [3:0] oh(int c);
    return 4'(1) << c;
  endfunction

  // Round-robin rule: first pending channel after the last winner.
  function automatic int pick(logic [3:0] p, int ptr);
    for (int k = 1; k <= NCH; k++)
      if (p[(ptr + k) % NCH]) return (ptr + k) % NCH;
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic        endp;
    logic        bufe;
    logic [3:0]  gnt;
    logic        sof;
    logic        busy;
    logic [3:0]  done;
    logic [3:0]  rej;
    logic        clr;
    logic [31:0] dar;
  } vec_t;

  vec_t tv[16];

  task automatic apply(vec_t v);
    ch_req      = v.req;
    dma_cmd_end = v.endp;
    buf_err     = v.bufe;
  endtask

  // Transaction-level model state
  logic [3:0]  pending;
  logic [3:0]  drop_pend;
  int          m_ptr;
  int          cur;
  int          exp_next;
  bit          exp_busy;
  bit          exp_done;
  bit          exp_bufe;
  int          end_cnt;
  int          lowcnt;
  int          wait_cnt;
  logic [31:0] s_dar;
  logic [15:0] s_xs;
  logic [15:0] s_ys;
  logic [15:0] s_yst;
  int          order[$];

  task automatic model_reset();
    pending   = '0;
    drop_pend = '0;
    m_ptr     = NCH - 1;
    cur       = 0;
    exp_next  = 0;
    exp_busy  = 0;
    exp_done  = 0;
    exp_bufe  = 0;
    end_cnt   = -1;
    lowcnt    = 100;
    wait_cnt  = 0;
    order.delete();
  endtask

  task automatic new_desc(int i);
    int r;
    r = $urandom_range(0, 9);
    m_dar[i] = $urandom;
    m_ys[i]  = 16'($urandom);
    m_yst[i] = 16'($urandom);
    if (r == 0)      m_xs[i] = 16'h0FFF;
    else if (r == 1) m_xs[i] = 16'h1000;
    else if (r == 2) m_xs[i] = 16'($urandom_range(16'h1001, 16'hFFFF));
    else             m_xs[i] = 16'($urandom_range(0, 16'h0FFE));
  endtask

  task automatic step(bit rnd, int fixd);
    int w;
    int was_next;
    bit gseen;
    w = -1;
    gseen = 0;
    @(negedge clk);
    if (dma_busy) lowcnt = 0;
    else lowcnt++;
    was_next = exp_next;
    chk("sof", 32'(dma_cmd_sof), 32'(was_next == 1));
    chk("rej", 32'(ch_rej), 32'(was_next == 2 ? oh(cur) : 4'h0));
    if (was_next == 1) begin
      chk("cfg_dar", cfg_dar, s_dar);
      chk("cfg_xs", 32'(cfg_trans_xsize), 32'(s_xs));
      chk("cfg_ys", 32'(cfg_trans_ysize), 32'(s_ys));
      chk("cfg_yst", 32'(cfg_da_ystep), 32'(s_yst));
      chk("cur_ch", 32'(cur_ch), 32'(cur));
    end
    exp_next = 0;
    chk("done", 32'(ch_done), 32'(exp_done ? oh(cur) : 4'h0));
    chk("clr", 32'(clr_buf_err), 32'(exp_done && exp_bufe));
    chk("busy", 32'(dma_busy), 32'(exp_busy));
    if (was_next == 1) exp_busy = 1;
    if (exp_done) exp_busy = 0;
    exp_done = 0;
    if (was_next == 1) end_cnt = rnd ? $urandom_range(2, 8) : fixd;
    if (ch_gnt != 4'h0) begin
      gseen = 1;
      w = pick(pending, m_ptr);
      chk("gnt", 32'(ch_gnt), 32'(w < 0 ? 4'h0 : oh(w)));
      if (w >= 0) begin
        chk("gap", 32'(lowcnt >= 2), 32'(1));
        m_ptr = w;
        cur   = w;
        s_dar = m_dar[w];
        s_xs  = m_xs[w];
        s_ys  = m_ys[w];
        s_yst = m_yst[w];
        exp_next = (m_xs[w] > 16'h0FFF) ? 2 : 1;
        order.push_back(w);
      end
      wait_cnt = 0;
    end else if (pending != 4'h0) begin
      wait_cnt++;
      if (wait_cnt > 40) begin
        total++;
        bad++;
        $display("FAIL gnt_timeout act=none exp=%b", pending);
        wait_cnt = 0;
      end
    end
    pending   = pending & ~drop_pend;
    drop_pend = (gseen && w >= 0) ? oh(w) : 4'h0;
    dma_cmd_end = 1'b0;
    buf_err     = 1'b0;
    if (end_cnt == 0) begin
      dma_cmd_end = 1'b1;
      exp_bufe    = 1'($urandom_range(0, 1));
      buf_err     = exp_bufe;
      exp_done    = 1;
      end_cnt     = -1;
    end else if (end_cnt > 0) begin
      end_cnt--;
    end else if (rnd && !exp_busy && exp_next == 0
                 && $urandom_range(0, 15) == 0) begin
      dma_cmd_end = 1'b1;
    end
    if (rnd && !gseen) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pending[i] && $urandom_range(0, 7) == 0) begin
          new_desc(i);
          pending[i] = 1'b1;
        end
      end
    end
    ch_req = pending;
    put_desc();
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ch_req = '0;
    dma_cmd_end = 1'b0;
    buf_err = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_dar[i] = 32'h0;
      m_xs[i]  = 16'h0;
      m_ys[i]  = 16'h0;
      m_yst[i] = 16'h0;
    end
    m_dar[1] = 32'h1000_0002; m_xs[1] = 16'd7;
    m_ys[1]  = 16'd3;         m_yst[1] = 16'd64;
    m_dar[2] = 32'h2000_0000; m_xs[2] = 16'h1000;
    m_dar[3] = 32'h3000_0003; m_xs[3] = 16'd5;
    put_desc();

    tv[0]  = '{4'b0010, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};
    tv[1]  = '{4'b0010, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 32'h1000_0002};
    tv[2]  = '{4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 32'h0};
    tv[3]  = '{4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 32'h0};
    tv[4]  = '{4'b0000, 1, 0, 4'b0000, 0, 1, 4'b0010, 4'b0000, 0, 32'h0};
    tv[5]  = '{4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};
    tv[6]  = '{4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};
    tv[7]  = '{4'b1100, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};
    tv[8]  = '{4'b1100, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 0, 32'h0};
    tv[9]  = '{4'b1000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};
    tv[10] = '{4'b1000, 0, 0, 4'b1000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};
    tv[11] = '{4'b1000, 0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 32'h3000_0003};
    tv[12] = '{4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 32'h0};
    tv[13] = '{4'b0000, 0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 32'h0};
    tv[14] = '{4'b0000, 1, 1, 4'b0000, 0, 1, 4'b1000, 4'b0000, 1, 32'h0};
    tv[15] = '{4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(ch_gnt), 32'h0);
    chk("rst_busy", 32'(dma_busy), 32'h0);
    chk("rst_sof", 32'(dma_cmd_sof), 32'h0);
    chk("rst_cfg", cfg_dar, 32'h0);
    chk("rst_cur", 32'(cur_ch), 32'h0);
    chk("rst_wdog", 32'(wdog_err), 32'h0);
    rst = 1'b0;

    // Vector table: single request, then reject followed by normal ch3
    apply(tv[0]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("t%0d_gnt", i), 32'(ch_gnt), 32'(tv[i].gnt));
      chk($sformatf("t%0d_sof", i), 32'(dma_cmd_sof), 32'(tv[i].sof));
      chk($sformatf("t%0d_busy", i), 32'(dma_busy), 32'(tv[i].busy));
      chk($sformatf("t%0d_done", i), 32'(ch_done), 32'(tv[i].done));
      chk($sformatf("t%0d_rej", i), 32'(ch_rej), 32'(tv[i].rej));
      chk($sformatf("t%0d_clr", i), 32'(clr_buf_err), 32'(tv[i].clr));
      if (tv[i].sof) chk($sformatf("t%0d_dar", i), cfg_dar, tv[i].dar);
      if (i < 15) apply(tv[i+1]);
    end
    apply(tv[15]);

    // Reset in the middle of a running transfer
    ch_req = 4'b0010;
    repeat (2) @(negedge clk);
    ch_req = 4'b0000;
    @(negedge clk);
    chk("mid_busy_pre", 32'(dma_busy), 32'h1);
    #1 rst = 1'b1;
    #1 chk("mid_busy_rst", 32'(dma_busy), 32'h0);
    chk("mid_done_rst", 32'(ch_done), 32'h0);
    @(negedge clk);
    chk("mid_done_a", 32'(ch_done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_done_b", 32'(ch_done), 32'h0);
    chk("mid_busy_b", 32'(dma_busy), 32'h0);

    // All channels at once, fixed 10-cycle transfers
    model_reset();
    m_xs[0] = 16'h0FFF; m_dar[0] = 32'hA000_0000;
    m_xs[2] = 16'd9;    m_dar[2] = 32'hC000_0000;
    pending = 4'hF;
    ch_req  = pending;
    put_desc();
    repeat (80) step(0, 10);
    chk("all4_n", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk($sformatf("all4_ord%0d", i), 32'(order[i]), 32'(i));
    chk("all4_pend", 32'(pending), 32'h0);

    // Randomized traffic, then drain
    repeat (3000) step(1, 0);
    repeat (200) step(0, 4);
    chk("drain_pend", 32'(pending), 32'h0);
    chk("drain_busy", 32'(dma_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
